wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 110 +++++++++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage with the 31x32 MIPS register file, commit
//               counter and forwarding outputs. Macro WB_REGFILE_BYPASS_EN
//               enables same-cycle write-before-read on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] WB_aluResult,
    input  logic [31:0] WB_dmOut,
    input  logic [31:0] WB_pc4,
    input  logic [1:0]  WB_RegSrc,
    input  logic [4:0]  WB_rt,
    input  logic [4:0]  WB_rd,
    input  logic [1:0]  WB_RegDst,
    input  logic        WB_RegWrite,
    input  logic [4:0]  ID_rsAddr,
    input  logic [4:0]  ID_rtAddr,
    output logic [31:0] ID_rsData,
    output logic [31:0] ID_rtData,
    output logic [4:0]  WB_wAddr,
    output logic [31:0] WB_wData,
    output logic        WB_wEn,
    output logic [31:0] WB_commitCnt
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DM   = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;
    localparam logic [1:0] RESERVED = 2'b11;

    // $0 is hardwired, so only $1..$31 have storage
    logic [31:0] regs [1:31];
    logic [31:0] commit_cnt;

    always_comb begin
        WB_wData = 32'h0;
        case (WB_RegSrc)
            SRC_ALU: WB_wData = WB_aluResult;
            SRC_DM:  WB_wData = WB_dmOut;
            SRC_PC4: WB_wData = WB_pc4;
            default: WB_wData = 32'h0;
        endcase
    end

    always_comb begin
        WB_wAddr = 5'd0;
        case (WB_RegDst)
            DST_RT:   WB_wAddr = WB_rt;
            DST_RD:   WB_wAddr = WB_rd;
            DST_LINK: WB_wAddr = 5'd31;
            default:  WB_wAddr = 5'd0;
        endcase
    end

    assign WB_wEn = WB_RegWrite && (WB_wAddr != 5'd0)
                 && (WB_RegSrc != RESERVED) && (WB_RegDst != RESERVED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (WB_wEn) begin
            regs[WB_wAddr] <= WB_wData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= 32'h0;
        end else if (WB_wEn) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end

    assign WB_commitCnt = commit_cnt;

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] value;
        value = 32'h0;
        if (addr != 5'd0) begin
`ifdef WB_REGFILE_BYPASS_EN
            if (WB_wEn && (addr == WB_wAddr)) begin
                value = WB_wData;
            end else begin
                value = regs[addr];
            end
`else
            value = regs[addr];
`endif
        end
        return value;
    endfunction

    always_comb begin
        ID_rsData = read_port(ID_rsAddr);
        ID_rtData = read_port(ID_rtAddr);
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed self-checking bench for wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] WB_aluResult;
    logic [31:0] WB_dmOut;
    logic [31:0] WB_pc4;
    logic [1:0]  WB_RegSrc;
    logic [4:0]  WB_rt;
    logic [4:0]  WB_rd;
    logic [1:0]  WB_RegDst;
    logic        WB_RegWrite;
    logic [4:0]  ID_rsAddr;
    logic [4:0]  ID_rtAddr;
    logic [31:0] ID_rsData;
    logic [31:0] ID_rtData;
    logic [4:0]  WB_wAddr;
    logic [31:0] WB_wData;
    logic        WB_wEn;
    logic [31:0] WB_commitCnt;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WB_aluResult (WB_aluResult),
        .WB_dmOut     (WB_dmOut),
        .WB_pc4       (WB_pc4),
        .WB_RegSrc    (WB_RegSrc),
        .WB_rt        (WB_rt),
        .WB_rd        (WB_rd),
        .WB_RegDst    (WB_RegDst),
        .WB_RegWrite  (WB_RegWrite),
        .ID_rsAddr    (ID_rsAddr),
        .ID_rtAddr    (ID_rtAddr),
        .ID_rsData    (ID_rsData),
        .ID_rtData    (ID_rtData),
        .WB_wAddr     (WB_wAddr),
        .WB_wData     (WB_wData),
        .WB_wEn       (WB_wEn),
        .WB_commitCnt (WB_commitCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reads a register through both ports and checks each
    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        ID_rsAddr = addr;
        ID_rtAddr = addr;
        #1;
        check_value({tag, "_rs"}, ID_rsData, exp);
        check_value({tag, "_rt"}, ID_rtData, exp);
    endtask

    task automatic setup_write(input logic we, input logic [1:0] dst, input logic [1:0] src,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] dm,
                               input logic [31:0] pc4);
        WB_RegWrite  = we;
        WB_RegDst    = dst;
        WB_RegSrc    = src;
        WB_rt        = rt;
        WB_rd        = rd;
        WB_aluResult = alu;
        WB_dmOut     = dm;
        WB_pc4       = pc4;
        #1;
    endtask

    // Take the edge, then drop RegWrite so later reads see stored state only
    task automatic clock_write();
        @(posedge clk);
        #1;
        WB_RegWrite = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ID_rsAddr = 5'd0;
        ID_rtAddr = 5'd0;
        setup_write(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #11;
        check_reg("reset_r5", 5'd5, 32'h0);
        check_reg("reset_r31", 5'd31, 32'h0);
        check_value("reset_cnt", WB_commitCnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result to rd=5
        @(negedge clk);
        setup_write(1'b1, 2'b01, 2'b00, 5'd9, 5'd5, 32'h1234, 32'hDEAD, 32'h4);
        check_value("alu_waddr", {27'b0, WB_wAddr}, 32'd5);
        check_value("alu_wdata", WB_wData, 32'h1234);
        check_value("alu_wen", {31'b0, WB_wEn}, 32'd1);
        clock_write();
        check_reg("alu_r5", 5'd5, 32'h1234);
        check_value("alu_cnt", WB_commitCnt, 32'd1);

        // Link write of PC+4 to $31
        @(negedge clk);
        setup_write(1'b1, 2'b10, 2'b10, 5'd3, 5'd4, 32'h1, 32'h2, 32'h00400008);
        check_value("link_waddr", {27'b0, WB_wAddr}, 32'd31);
        clock_write();
        check_reg("link_r31", 5'd31, 32'h00400008);
        check_value("link_cnt", WB_commitCnt, 32'd2);

        // DM load to rt=9
        @(negedge clk);
        setup_write(1'b1, 2'b00, 2'b01, 5'd9, 5'd2, 32'h1, 32'hCAFE0001, 32'h0);
        check_value("dm_wdata", WB_wData, 32'hCAFE0001);
        clock_write();
        check_reg("dm_r9", 5'd9, 32'hCAFE0001);
        check_reg("dm_r2_untouched", 5'd2, 32'h0);
        check_value("dm_cnt", WB_commitCnt, 32'd3);

        // Destination $0 suppressed
        @(negedge clk);
        setup_write(1'b1, 2'b00, 2'b01, 5'd0, 5'd5, 32'h0, 32'hFFFF, 32'h0);
        check_value("zero_wen", {31'b0, WB_wEn}, 32'd0);
        clock_write();
        check_reg("zero_r0", 5'd0, 32'h0);
        check_reg("zero_r5_kept", 5'd5, 32'h1234);
        check_value("zero_cnt", WB_commitCnt, 32'd3);

        // Reserved RegSrc suppressed, data forced to 0
        @(negedge clk);
        setup_write(1'b1, 2'b01, 2'b11, 5'd0, 5'd6, 32'h66, 32'h66, 32'h66);
        check_value("rsvsrc_wdata", WB_wData, 32'h0);
        check_value("rsvsrc_wen", {31'b0, WB_wEn}, 32'd0);
        clock_write();
        check_reg("rsvsrc_r6", 5'd6, 32'h0);
        check_value("rsvsrc_cnt", WB_commitCnt, 32'd3);

        // Reserved RegDst suppressed, address forced to 0
        @(negedge clk);
        setup_write(1'b1, 2'b11, 2'b00, 5'd6, 5'd6, 32'h77, 32'h0, 32'h0);
        check_value("rsvdst_waddr", {27'b0, WB_wAddr}, 32'd0);
        check_value("rsvdst_wen", {31'b0, WB_wEn}, 32'd0);
        clock_write();
        check_reg("rsvdst_r6", 5'd6, 32'h0);
        check_value("rsvdst_cnt", WB_commitCnt, 32'd3);

        // RegWrite low: nothing written
        @(negedge clk);
        setup_write(1'b0, 2'b01, 2'b00, 5'd0, 5'd8, 32'h88, 32'h0, 32'h0);
        clock_write();
        check_reg("nowe_r8", 5'd8, 32'h0);
        check_value("nowe_cnt", WB_commitCnt, 32'd3);

        // Same-cycle read of the register being written
        @(negedge clk);
        setup_write(1'b1, 2'b01, 2'b00, 5'd0, 5'd7, 32'hA5A5A5A5, 32'h0, 32'h0);
        ID_rsAddr = 5'd7;
        ID_rtAddr = 5'd5;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check_value("same_cycle_rs", ID_rsData, 32'hA5A5A5A5);
`else
        check_value("same_cycle_rs", ID_rsData, 32'h0);
`endif
        check_value("same_cycle_rt_other", ID_rtData, 32'h1234);
        clock_write();
        check_reg("same_cycle_r7", 5'd7, 32'hA5A5A5A5);
        check_value("same_cycle_cnt", WB_commitCnt, 32'd4);

        // Asynchronous reset pulse between edges, with a write pending
        @(negedge clk);
        setup_write(1'b1, 2'b01, 2'b00, 5'd0, 5'd10, 32'h77, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_value("arst_cnt", WB_commitCnt, 32'h0);
        check_reg("arst_r5", 5'd5, 32'h0);
        check_reg("arst_r31", 5'd31, 32'h0);
        check_reg("arst_r7", 5'd7, 32'h0);
        clock_write();
        check_reg("arst_r10_blocked", 5'd10, 32'h0);
        check_value("arst_cnt_blocked", WB_commitCnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        WB_RegWrite = 1'b1;
        clock_write();
        check_reg("post_rst_r10", 5'd10, 32'h77);
        check_value("post_rst_cnt", WB_commitCnt, 32'd1);

        // Counter wrap from preloaded all-ones
        @(negedge clk);
        dut.commit_cnt = 32'hFFFFFFFF;
        setup_write(1'b1, 2'b01, 2'b00, 5'd0, 5'd12, 32'h12, 32'h0, 32'h0);
        check_value("wrap_preload", WB_commitCnt, 32'hFFFFFFFF);
        clock_write();
        check_value("wrap_cnt", WB_commitCnt, 32'h0);
        check_reg("wrap_r12", 5'd12, 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
